// File: rtl/audio_dac_serializer.sv
// Audio-out transmit path: buffers stereo pairs in a small FIFO and shifts them
// out MSB-first in I2S format against the codec-mastered BCLK/DACLRCK.
module audio_dac_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0]         right_channel_audio_out,
  input  logic                          write_audio_out,
  output logic                          audio_out_allowed,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Codec clock synchronisers with one history flop for edge detection
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic       bclk_hist;
  logic       lrck_hist;
  logic       bclk_fall_c;
  logic       lrck_fall_c;
  logic       lrck_rise_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_hist <= 1'b0;
      lrck_hist <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_DACLRCK};
      bclk_hist <= bclk_sync[1];
      lrck_hist <= lrck_sync[1];
    end
  end

  assign bclk_fall_c = bclk_hist & ~bclk_sync[1];
  assign lrck_fall_c = lrck_hist & ~lrck_sync[1];
  assign lrck_rise_c = ~lrck_hist & lrck_sync[1];

  // Serializer state machine
  state_t state_q;
  state_t state_d;
  logic   pop_c;
  logic   load_right_c;
  logic   serial_en_c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (lrck_fall_c) state_d = ST_LEFT;
      ST_LEFT:  if (lrck_rise_c) state_d = ST_RIGHT;
      ST_RIGHT: if (lrck_fall_c) state_d = ST_LEFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_c        = 1'b0;
    load_right_c = 1'b0;
    serial_en_c  = 1'b0;
    case (state_q)
      ST_IDLE:  pop_c = lrck_fall_c;
      ST_LEFT: begin
        load_right_c = lrck_rise_c;
        serial_en_c  = 1'b1;
      end
      ST_RIGHT: begin
        pop_c       = lrck_fall_c;
        serial_en_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Sample-pair FIFO
  pair_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_c;
  logic               do_pop_c;
  logic [LVL_W-1:0]   level_nxt_c;
  pair_t              head_c;

  assign push_c      = write_audio_out & audio_out_allowed;
  assign do_pop_c    = pop_c & (fifo_level != '0);
  assign level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(do_pop_c);
  assign head_c      = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      audio_out_allowed <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= '{left: left_channel_audio_out, right: right_channel_audio_out};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level        <= level_nxt_c;
      audio_out_allowed <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
    end
  end

  // Shift datapath: an LRCK edge restarts the half, truncating any unsent bits
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q    <= '0;
      hold_q     <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      underflow <= pop_c & (fifo_level == '0);
      if (pop_c) begin
        shift_q <= do_pop_c ? head_c.left  : '0;
        hold_q  <= do_pop_c ? head_c.right : '0;
        bit_cnt <= '0;
        if (bclk_fall_c) AUD_DACDAT <= 1'b0;
      end else if (load_right_c) begin
        shift_q <= hold_q;
        bit_cnt <= '0;
        if (bclk_fall_c) AUD_DACDAT <= 1'b0;
      end else if (serial_en_c && bclk_fall_c) begin
        if (bit_cnt != CNT_W'(DATA_WIDTH)) begin
          AUD_DACDAT <= shift_q[DATA_WIDTH-1];
          shift_q    <= shift_q << 1;
          bit_cnt    <= bit_cnt + CNT_W'(1);
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule
